// File: rtl/md_pad_pkg.sv
// Purpose : shared constants and the pad line multiplexer for the Mega Drive pad emulator.
// Latency : n/a (package: constants and a combinational helper only).
// Backpressure: n/a.
package md_pad_pkg;

    // Button vector bit positions (pressed = 1)
    localparam int BTN_U     = 0;
    localparam int BTN_D     = 1;
    localparam int BTN_L     = 2;
    localparam int BTN_R     = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_X     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_Z     = 10;
    localparam int BTN_MODE  = 11;
    localparam int NUM_BTN   = 12;

    // Pad line positions on pad_n (DB9 pin numbers in the names)
    localparam int PAD_P1  = 0;
    localparam int PAD_P2  = 1;
    localparam int PAD_P3  = 2;
    localparam int PAD_P4  = 3;
    localparam int PAD_P6  = 4;
    localparam int PAD_P9  = 5;
    localparam int NUM_PAD = 6;

    // Count of select falling edges seen in the current polling burst
    typedef logic [2:0] phase_t;

    localparam phase_t PH_IDLE   = 3'd0;
    localparam phase_t PH_FIRST  = 3'd1;
    localparam phase_t PH_SECOND = 3'd2;
    localparam phase_t PH_ID     = 3'd3;
    localparam phase_t PH_END    = 3'd4;

    // Active-low pad lines for a given select level and phase.
    // A pressed button pulls its line low.
    function automatic logic [NUM_PAD-1:0] pad_mux(
        input logic               sel_s,
        input phase_t             ph,
        input logic [NUM_BTN-1:0] btn
    );
        logic [NUM_BTN-1:0] n;
        logic [NUM_PAD-1:0] p;
        n = ~btn;
        p = '1;
        if (sel_s) begin
            if (ph == PH_ID) begin
                p[PAD_P1] = n[BTN_Z];
                p[PAD_P2] = n[BTN_Y];
                p[PAD_P3] = n[BTN_X];
                p[PAD_P4] = n[BTN_MODE];
            end else begin
                p[PAD_P1] = n[BTN_U];
                p[PAD_P2] = n[BTN_D];
                p[PAD_P3] = n[BTN_L];
                p[PAD_P4] = n[BTN_R];
            end
            p[PAD_P6] = n[BTN_B];
            p[PAD_P9] = n[BTN_C];
        end else begin
            case (ph)
                // All four direction lines low identifies a 6-button pad
                PH_ID:   p[PAD_P4:PAD_P1] = 4'b0000;
                // All four high tells the reader the sequence is over
                PH_END:  p[PAD_P4:PAD_P1] = 4'b1111;
                default: begin
                    p[PAD_P1] = n[BTN_U];
                    p[PAD_P2] = n[BTN_D];
                    p[PAD_P3] = 1'b0;
                    p[PAD_P4] = 1'b0;
                end
            endcase
            p[PAD_P6] = n[BTN_A];
            p[PAD_P9] = n[BTN_START];
        end
        return p;
    endfunction

endpackage

// File: rtl/md_pad_emu_sync_ff.sv
// Purpose : multi-flop synchronizer for a single asynchronous bit; flops reset to 1.
// Latency : STAGES cycles from d_i to q_o.
// Backpressure: none, free-running.
// Ports   : clk_i, reset_i (sync, active-high), d_i (async input), q_o (synchronized).
module sync_ff #(
    parameter int STAGES = 2    // minimum 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/md_pad_emu.sv
// Purpose : emulates a Mega Drive 3/6-button pad answering a host select line.
// Latency : sel -> pad_n SYNC_STAGES+1 cycles; btn -> pad_n 1 cycle.
// Backpressure: none; the pad answers every select level, the host paces the protocol.
// Ports   : clk_peripheral, reset (sync, active-high), btn[11:0] (pressed=1),
//           sel (async host select), pad_n[5:0] (active-low pins 1,2,3,4,6,9), phase[2:0].
// Config  : MD_PAD_SIX_BTN_EN enables the 6-button sequence (phase counter + idle timer);
//           without it the pad behaves as a 3-button pad and phase reads 0.
module md_pad_emu #(
    parameter int TIMEOUT_CYC = 28000,  // idle cycles before the phase counter rewinds
    parameter int SYNC_STAGES = 2       // select synchronizer depth, minimum 2
) (
    input  logic        clk_peripheral,
    input  logic        reset,
    input  logic [11:0] btn,
    input  logic        sel,
    output logic [5:0]  pad_n,
    output logic [2:0]  phase
);

    import md_pad_pkg::*;

    if (SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("md_pad_emu: SYNC_STAGES must be >= 2 and TIMEOUT_CYC >= 1");
    end

    logic                sel_s;
    phase_t              phase_d;
    logic [NUM_PAD-1:0]  pad_d;
    logic [NUM_PAD-1:0]  pad_q;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sel_sync (
        .clk_i   (clk_peripheral),
        .reset_i (reset),
        .d_i     (sel),
        .q_o     (sel_s)
    );

`ifdef MD_PAD_SIX_BTN_EN
    localparam int                 TIMER_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYC);

    logic               sel_d_q;
    logic               fall;
    logic               sel_edge;
    logic               timeout;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;
    phase_t             phase_q;

    always_comb begin
        fall     = sel_d_q & ~sel_s;
        sel_edge = sel_d_q ^ sel_s;
        timeout  = (timer_q == TIMER_MAX);
        timer_d  = timer_q;
        phase_d  = phase_q;

        // Timer measures time since the last select activity and parks at the limit
        if (sel_edge) begin
            timer_d = '0;
        end else if (!timeout) begin
            timer_d = timer_q + TIMER_W'(1);
        end

        // A fall landing on the timeout cycle starts a fresh burst rather than
        // being lost to the rewind
        if (fall) begin
            if (timeout) begin
                phase_d = PH_FIRST;
            end else if (phase_q == PH_END) begin
                phase_d = PH_END;
            end else begin
                phase_d = phase_q + 3'd1;
            end
        end else if (timeout) begin
            phase_d = PH_IDLE;
        end
    end

    always_ff @(posedge clk_peripheral) begin
        if (reset) begin
            sel_d_q <= 1'b1;
            timer_q <= '0;
            phase_q <= PH_IDLE;
        end else begin
            sel_d_q <= sel_s;
            timer_q <= timer_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;
`else
    // 3-button pad: the mux never leaves the normal halves, so btn[11:8] has no effect
    assign phase_d = PH_IDLE;
    assign phase   = PH_IDLE;
`endif

    // Mux on the next phase so the data for a new low half is right from its first cycle
    always_comb begin
        pad_d = pad_mux(sel_s, phase_d, btn);
    end

    always_ff @(posedge clk_peripheral) begin
        if (reset) begin
            pad_q <= '1;
        end else begin
            pad_q <= pad_d;
        end
    end

    assign pad_n = pad_q;

endmodule

// File: tb/tb_md_pad_emu.sv
// Purpose : self-checking bench for md_pad_emu; random select/button traffic against a
//           protocol-level model that counts select falls between idle gaps.
// Latency : n/a. Backpressure: n/a.
module tb_md_pad_emu;

    localparam int TO  = 16;
    localparam int SYN = 2;
`ifdef MD_PAD_SIX_BTN_EN
    localparam bit SIX = 1'b1;
`else
    localparam bit SIX = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] btn;
    logic        sel;
    logic [5:0]  pad_n;
    logic [2:0]  phase;

    int n_vec = 0;
    int n_err = 0;

    // Model state: level the host drives, falls counted in this burst,
    // and cycles since the host last changed sel
    logic m_sel;
    int   m_phase;
    int   m_gap;

    md_pad_emu #(
        .TIMEOUT_CYC (TO),
        .SYNC_STAGES (SYN)
    ) dut (
        .clk_peripheral (clk),
        .reset          (reset),
        .btn            (btn),
        .sel            (sel),
        .pad_n          (pad_n),
        .phase          (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Pad lines the protocol table calls for
    function automatic logic [5:0] exp_pad(input logic s, input int ph, input logic [11:0] b);
        logic [5:0] p;
        if (!s && ph == 3)      p = {~b[7], ~b[4], 4'b0000};
        else if (!s && ph == 4) p = {~b[7], ~b[4], 4'b1111};
        else if (!s)            p = {~b[7], ~b[4], 2'b00, ~b[1], ~b[0]};
        else if (ph == 3)       p = {~b[6], ~b[5], ~b[11], ~b[8], ~b[9], ~b[10]};
        else                    p = {~b[6], ~b[5], ~b[3], ~b[2], ~b[1], ~b[0]};
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        m_gap++;
    endtask

    // Host changes sel: a gap longer than the timeout rewinds the burst first,
    // then a fall counts (saturating at 4)
    task automatic model_sel(input logic v);
        if (v != m_sel) begin
            if (m_gap >= TO + 1) m_phase = 0;
            if (m_sel && !v) m_phase = (m_phase >= 4) ? 4 : m_phase + 1;
            if (!SIX) m_phase = 0;
            m_gap = 0;
            m_sel = v;
        end
        sel = v;
    endtask

    // Compare only where the outcome is unambiguous: well before the timeout,
    // or long enough after it that the rewind has reached the outputs
    task automatic check_state(input string tag);
        if (m_gap <= TO - 1) begin
            chk({tag, "_pad"}, 8'(pad_n), 8'(exp_pad(m_sel, m_phase, btn)));
            chk({tag, "_phase"}, 8'(phase), 8'(m_phase));
        end else if (m_gap >= TO + 6) begin
            m_phase = 0;
            chk({tag, "_pad"}, 8'(pad_n), 8'(exp_pad(m_sel, 0, btn)));
            chk({tag, "_phase"}, 8'(phase), 8'd0);
        end
    endtask

    task automatic do_period(input string tag, input logic v, input int g, input logic [11:0] b);
        btn = b;
        model_sel(v);
        repeat (g) tick();
        check_state(tag);
    endtask

    initial begin
        // Reset with sel low and every button pressed: lines must stay released
        reset   = 1'b1;
        sel     = 1'b0;
        btn     = 12'hFFF;
        m_sel   = 1'b1;
        m_phase = 0;
        m_gap   = 0;
        repeat (3) tick();
        chk("rst_pad", 8'(pad_n), 8'h3F);
        chk("rst_phase", 8'(phase), 8'd0);

        // Button to pad latency: one cycle
        reset = 1'b0;
        sel   = 1'b1;
        btn   = 12'h001;
        m_gap = 0;
        tick();
        chk("btn_lat_pad", 8'(pad_n), 8'b0011_1110);

        // Select to pad latency: SYNC_STAGES+1 cycles
        model_sel(1'b0);
        tick();
        tick();
        chk("sel_lat2_pad", 8'(pad_n), 8'b0011_1110);
        tick();
        chk("sel_lat3_pad", 8'(pad_n), 8'b0011_0010);
        chk("first_fall_phase", 8'(phase), 8'(m_phase));

        btn = 12'h030;
        tick();
        chk("btn_lat_low_pad", 8'(pad_n), 8'(exp_pad(m_sel, m_phase, btn)));

        // Idle rewind, then a full four-pulse burst with X held
        do_period("idle", 1'b1, 30, 12'h100);
        for (int k = 0; k < 4; k++) begin
            do_period("burst_lo", 1'b0, 5, 12'h100);
            do_period("burst_hi", 1'b1, 5, 12'h100);
        end
        // A fifth fall stays parked at the end phase
        do_period("sat_lo", 1'b0, 5, 12'h100);
        do_period("sat_hi", 1'b1, 5, 12'h100);

        // Two pulses, idle past the timeout, next pulse is a normal low half
        do_period("to_idle", 1'b1, 30, 12'hFF0);
        do_period("to_lo1", 1'b0, 5, 12'hFF0);
        do_period("to_hi1", 1'b1, 5, 12'hFF0);
        do_period("to_lo2", 1'b0, 5, 12'hFF0);
        do_period("to_hold", 1'b1, 25, 12'hFF0);
        do_period("to_after", 1'b0, 6, 12'hFF0);

        // Fall landing exactly on the timeout cycle versus one cycle earlier
        do_period("co_idle", 1'b1, 30, 12'h0F0);
        do_period("co_lo1", 1'b0, 5, 12'h0F0);
        do_period("co_hi1", 1'b1, 5, 12'h0F0);
        do_period("co_lo2", 1'b0, 5, 12'h0F0);
        do_period("co_hold", 1'b1, TO + 1, 12'h0F0);
        do_period("co_fall", 1'b0, 8, 12'h0F0);
        do_period("nc_hi", 1'b1, 5, 12'h0F0);
        do_period("nc_lo", 1'b0, 5, 12'h0F0);
        do_period("nc_hold", 1'b1, TO, 12'h0F0);
        do_period("nc_fall", 1'b0, 8, 12'h0F0);

        // Three-button build: btn[11:8] pressed must never show up
        do_period("ext_idle", 1'b1, 30, 12'hF00);
        for (int k = 0; k < 4; k++) begin
            do_period("ext_lo", 1'b0, 5, 12'hF00);
            do_period("ext_hi", 1'b1, 5, 12'hF00);
        end

        // Reset in the middle of a burst
        do_period("mid_lo", 1'b0, 5, 12'h0A5);
        do_period("mid_hi", 1'b1, 5, 12'h0A5);
        do_period("mid_lo2", 1'b0, 5, 12'h0A5);
        reset = 1'b1;
        sel   = 1'b1;
        tick();
        tick();
        chk("mid_rst_pad", 8'(pad_n), 8'h3F);
        chk("mid_rst_phase", 8'(phase), 8'd0);
        reset   = 1'b0;
        m_sel   = 1'b1;
        m_phase = 0;
        m_gap   = 0;
        do_period("post_rst_lo", 1'b0, 6, 12'h0A5);

        // Random traffic: short gaps inside a burst, long gaps that rewind it
        for (int i = 0; i < 80; i++) begin
            logic        v;
            int          g;
            logic [11:0] b;
            v = ($urandom_range(0, 3) != 0) ? ~m_sel : m_sel;
            g = ($urandom_range(0, 3) != 0) ? int'($urandom_range(4, 12))
                                            : int'($urandom_range(TO + 6, TO + 14));
            b = 12'($urandom);
            do_period("rand", v, g, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
